// File: rtl/tlk2711_regif_pkg.sv
// Shared definitions for the TLK2711 AXI4-Lite register bridge.
package tlk2711_regif_pkg;

    localparam int REG_ADDR_W = 16;
    localparam int REG_DATA_W = 64;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ISSUE,
        W_RESP
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ISSUE,
        R_WAIT,
        R_RESP
    } r_state_t;

endpackage

// File: rtl/tlk2711_axil_regif.sv
// AXI4-Lite slave that turns PS register accesses into the TLK2711 strobe/address/data
// register bus; one outstanding write and one outstanding read, write-first on collision.
module tlk2711_axil_regif
    import tlk2711_regif_pkg::*;
#(
    parameter int AXIL_ADDR_WIDTH = 16,
    parameter int DATA_WIDTH      = 64,
    parameter int RD_LATENCY      = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_axi_awvalid,
    output logic                         s_axi_awready,
    input  logic [AXIL_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                         s_axi_wvalid,
    output logic                         s_axi_wready,
    input  logic [DATA_WIDTH-1:0]        s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]      s_axi_wstrb,
    output logic                         s_axi_bvalid,
    input  logic                         s_axi_bready,
    output logic [1:0]                   s_axi_bresp,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    input  logic [AXIL_ADDR_WIDTH-1:0]   s_axi_araddr,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    output logic [DATA_WIDTH-1:0]        s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         o_reg_wen,
    output logic [REG_ADDR_W-1:0]        o_reg_waddr,
    output logic [REG_DATA_W-1:0]        o_reg_wdata,
    output logic                         o_reg_ren,
    output logic [REG_ADDR_W-1:0]        o_reg_raddr,
    input  logic [REG_DATA_W-1:0]        i_reg_rdata,
    output logic [15:0]                  o_err_cnt
);

    // RD_LATENCY is 1..4, so the wait counter never exceeds 3.
    localparam logic [2:0] LAT_LAST = 3'(RD_LATENCY - 1);

    w_state_t                w_state, w_next;
    logic                    aw_held, w_held, aw_held_next, w_held_next;
    logic [REG_ADDR_W-1:0]   aw_addr;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    aw_hs, w_hs, wr_ok, wr_err;

    r_state_t                r_state, r_next;
    logic [REG_ADDR_W-1:0]   ar_addr;
    logic [2:0]              lat_cnt;
    logic                    ar_hs, rd_misaligned, rd_err, lat_done;

    logic [1:0]              err_inc;
    logic [16:0]             err_sum;

    assign aw_hs  = s_axi_awvalid & s_axi_awready;
    assign w_hs   = s_axi_wvalid & s_axi_wready;
    assign wr_ok  = (aw_addr[2:0] == 3'b000) && (&w_strb);
    assign wr_err = (w_state == W_ISSUE) && !wr_ok;

    assign o_reg_wen   = (w_state == W_ISSUE) && wr_ok;
    assign o_reg_waddr = aw_addr;
    assign o_reg_wdata = w_data;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_next       = w_state;
        aw_held_next = aw_held;
        w_held_next  = w_held;
        case (w_state)
            W_IDLE: begin
                aw_held_next = aw_held | aw_hs;
                w_held_next  = w_held | w_hs;
                if (aw_held_next && w_held_next) w_next = W_ISSUE;
            end
            W_ISSUE: begin
                w_next       = W_RESP;
                aw_held_next = 1'b0;
                w_held_next  = 1'b0;
            end
            W_RESP:  if (s_axi_bvalid && s_axi_bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state       <= W_IDLE;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            aw_addr       <= '0;
            w_data        <= '0;
            w_strb        <= '0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
        end else begin
            w_state       <= w_next;
            aw_held       <= aw_held_next;
            w_held        <= w_held_next;
            s_axi_awready <= (w_next == W_IDLE) && !aw_held_next;
            s_axi_wready  <= (w_next == W_IDLE) && !w_held_next;
            if (aw_hs) aw_addr <= s_axi_awaddr[REG_ADDR_W-1:0];
            if (w_hs) begin
                w_data <= s_axi_wdata;
                w_strb <= s_axi_wstrb;
            end
            if (w_state == W_ISSUE) begin
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end
        end
    end

    assign ar_hs         = s_axi_arvalid & s_axi_arready;
    assign rd_misaligned = (ar_addr[2:0] != 3'b000);
    assign rd_err        = (r_state == R_ISSUE) && rd_misaligned;
    assign lat_done      = (lat_cnt == LAT_LAST);

    // A read issue that lands on a write issue waits one cycle: write-first.
    assign o_reg_ren   = (r_state == R_ISSUE) && !rd_misaligned && (w_state != W_ISSUE);
    assign o_reg_raddr = ar_addr;

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_ISSUE;
            R_ISSUE: begin
                if (rd_misaligned)       r_next = R_RESP;
                else if (o_reg_ren)      r_next = R_WAIT;
            end
            R_WAIT:  if (lat_done) r_next = R_RESP;
            R_RESP:  if (s_axi_rvalid && s_axi_rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            ar_addr       <= '0;
            lat_cnt       <= '0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_OKAY;
        end else begin
            r_state       <= r_next;
            s_axi_arready <= (r_next == R_IDLE);
            if (ar_hs) ar_addr <= s_axi_araddr[REG_ADDR_W-1:0];
            lat_cnt <= (r_state == R_WAIT) ? lat_cnt + 3'd1 : 3'd0;
            if (rd_err) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= '0;
                s_axi_rresp  <= RESP_SLVERR;
            end else if ((r_state == R_WAIT) && lat_done) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= i_reg_rdata;
                s_axi_rresp  <= RESP_OKAY;
            end else if (s_axi_rvalid && s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

    // Both channels can fail in the same cycle, so the counter may step by two.
    assign err_inc = {1'b0, wr_err} + {1'b0, rd_err};
    assign err_sum = {1'b0, o_err_cnt} + {15'd0, err_inc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             o_err_cnt <= '0;
        else if (err_sum[16]) o_err_cnt <= 16'hFFFF;
        else                 o_err_cnt <= err_sum[15:0];
    end

endmodule

// File: tb/tb_tlk2711_axil_regif.sv
// Self-checking bench for tlk2711_axil_regif: directed cases plus randomized traffic
// checked against a word-addressed register model and cycle-level timing rules.
module tb_tlk2711_axil_regif;
    import tlk2711_regif_pkg::*;

    localparam int RD_LAT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_axi_awvalid = 1'b0, s_axi_awready;
    logic [15:0] s_axi_awaddr  = '0;
    logic        s_axi_wvalid  = 1'b0, s_axi_wready;
    logic [63:0] s_axi_wdata   = '0;
    logic [7:0]  s_axi_wstrb   = '0;
    logic        s_axi_bvalid, s_axi_bready = 1'b0;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_arvalid = 1'b0, s_axi_arready;
    logic [15:0] s_axi_araddr  = '0;
    logic        s_axi_rvalid, s_axi_rready = 1'b0;
    logic [63:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        o_reg_wen, o_reg_ren;
    logic [15:0] o_reg_waddr, o_reg_raddr;
    logic [63:0] o_reg_wdata;
    logic [63:0] i_reg_rdata = '0;
    logic [15:0] o_err_cnt;

    always #5 clk = ~clk;

    tlk2711_axil_regif #(
        .AXIL_ADDR_WIDTH(16),
        .DATA_WIDTH     (64),
        .RD_LATENCY     (RD_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_awaddr (s_axi_awaddr),
        .s_axi_wvalid (s_axi_wvalid),
        .s_axi_wready (s_axi_wready),
        .s_axi_wdata  (s_axi_wdata),
        .s_axi_wstrb  (s_axi_wstrb),
        .s_axi_bvalid (s_axi_bvalid),
        .s_axi_bready (s_axi_bready),
        .s_axi_bresp  (s_axi_bresp),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_araddr (s_axi_araddr),
        .s_axi_rvalid (s_axi_rvalid),
        .s_axi_rready (s_axi_rready),
        .s_axi_rdata  (s_axi_rdata),
        .s_axi_rresp  (s_axi_rresp),
        .o_reg_wen    (o_reg_wen),
        .o_reg_waddr  (o_reg_waddr),
        .o_reg_wdata  (o_reg_wdata),
        .o_reg_ren    (o_reg_ren),
        .o_reg_raddr  (o_reg_raddr),
        .i_reg_rdata  (i_reg_rdata),
        .o_err_cnt    (o_err_cnt)
    );

    int n_vec = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Register slave behind the bridge plus the bench's own expected register contents.
    logic [63:0] slave_mem [0:8191];
    logic [63:0] ref_mem   [0:8191];
    logic        pend_v    [0:3];
    logic [63:0] pend_d    [0:3];

    int cyc = 0;
    int wen_count = 0, ren_count = 0, both_count = 0;
    int last_wen_cyc = -100, last_ren_cyc = -100;
    int w_issue_cyc = -100;
    int err_exp = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        i_reg_rdata = pend_v[RD_LAT-1] ? pend_d[RD_LAT-1] : {$urandom, $urandom};
        for (int i = 3; i > 0; i--) begin
            pend_v[i] = pend_v[i-1];
            pend_d[i] = pend_d[i-1];
        end
        pend_v[0] = o_reg_ren;
        pend_d[0] = slave_mem[o_reg_raddr[15:3]];
        if (o_reg_wen) begin
            wen_count++;
            last_wen_cyc = cyc;
            slave_mem[o_reg_waddr[15:3]] = o_reg_wdata;
        end
        if (o_reg_ren) begin
            ren_count++;
            last_ren_cyc = cyc;
        end
        if (o_reg_wen && o_reg_ren) both_count++;
    end

    function automatic int err_bump(input int e);
        return (e >= 65535) ? 65535 : e + 1;
    endfunction

    task automatic axi_write(input logic [15:0] a, input logic [63:0] d, input logic [7:0] s,
                             input int aw_off, input int w_off, input int b_stall);
        bit aw_done = 0, w_done = 0;
        int t = 0, acc = 0, wen0;
        bit ok;
        ok   = (a[2:0] == 3'b000) && (s == 8'hFF);
        wen0 = wen_count;
        while (!(aw_done && w_done) && t < 40) begin
            s_axi_awvalid = !aw_done && (t >= aw_off);
            s_axi_awaddr  = a;
            s_axi_wvalid  = !w_done && (t >= w_off);
            s_axi_wdata   = d;
            s_axi_wstrb   = s;
            acc = cyc;
            if (s_axi_awvalid && s_axi_awready) aw_done = 1;
            if (s_axi_wvalid && s_axi_wready)   w_done  = 1;
            @(posedge clk); #1;
            t++;
        end
        s_axi_awvalid = 0;
        s_axi_wvalid  = 0;
        check("wr_accept", {63'd0, aw_done && w_done}, 64'd1);
        w_issue_cyc = acc + 1;
        if (ok) ref_mem[a[15:3]] = d;
        check("wr_wen_cycle", {63'd0, o_reg_wen}, {63'd0, ok});
        if (ok) begin
            check("wr_waddr", {48'd0, o_reg_waddr}, {48'd0, a});
            check("wr_wdata", o_reg_wdata, d);
        end
        @(posedge clk); #1;
        repeat (b_stall) begin
            check("wr_bvalid_hold", {63'd0, s_axi_bvalid}, 64'd1);
            check("wr_bresp_hold", {62'd0, s_axi_bresp}, {62'd0, ok ? RESP_OKAY : RESP_SLVERR});
            @(posedge clk); #1;
        end
        check("wr_bvalid", {63'd0, s_axi_bvalid}, 64'd1);
        check("wr_bresp", {62'd0, s_axi_bresp}, {62'd0, ok ? RESP_OKAY : RESP_SLVERR});
        s_axi_bready = 1;
        @(posedge clk); #1;
        s_axi_bready = 0;
        check("wr_bvalid_drop", {63'd0, s_axi_bvalid}, 64'd0);
        check("wr_ready_again", {62'd0, s_axi_awready, s_axi_wready}, 64'd3);
        check("wr_wen_count", 64'(wen_count - wen0), ok ? 64'd1 : 64'd0);
        if (!ok) err_exp = err_bump(err_exp);
    endtask

    task automatic axi_read(input logic [15:0] a, input int start_dly, input int r_stall);
        bit done = 0, ok;
        int t = 0, c0 = 0, ren0, exp_ren, exp_rv;
        logic [63:0] ed;
        repeat (start_dly) begin @(posedge clk); #1; end
        ok   = (a[2:0] == 3'b000);
        ren0 = ren_count;
        while (!done && t < 40) begin
            s_axi_arvalid = 1;
            s_axi_araddr  = a;
            c0 = cyc;
            if (s_axi_arready) done = 1;
            @(posedge clk); #1;
            t++;
        end
        s_axi_arvalid = 0;
        check("rd_accept", {63'd0, done}, 64'd1);
        t = 0;
        while (!s_axi_rvalid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        check("rd_rvalid_seen", {63'd0, s_axi_rvalid}, 64'd1);
        if (ok) begin
            exp_ren = c0 + 1 + ((w_issue_cyc == c0 + 1) ? 1 : 0);
            exp_rv  = exp_ren + 1 + RD_LAT;
            check("rd_ren_cycle", 64'(last_ren_cyc), 64'(exp_ren));
            check("rd_ren_count", 64'(ren_count - ren0), 64'd1);
        end else begin
            exp_rv = c0 + 2;
            check("rd_ren_count", 64'(ren_count - ren0), 64'd0);
        end
        check("rd_latency", 64'(cyc), 64'(exp_rv));
        ed = ok ? ref_mem[a[15:3]] : 64'd0;
        repeat (r_stall) begin
            check("rd_rvalid_hold", {63'd0, s_axi_rvalid}, 64'd1);
            check("rd_rdata_hold", s_axi_rdata, ed);
            @(posedge clk); #1;
        end
        check("rd_rdata", s_axi_rdata, ed);
        check("rd_rresp", {62'd0, s_axi_rresp}, {62'd0, ok ? RESP_OKAY : RESP_SLVERR});
        s_axi_rready = 1;
        @(posedge clk); #1;
        s_axi_rready = 0;
        check("rd_rvalid_drop", {63'd0, s_axi_rvalid}, 64'd0);
        check("rd_arready_again", {63'd0, s_axi_arready}, 64'd1);
        if (!ok) err_exp = err_bump(err_exp);
    endtask

    function automatic logic [15:0] rand_addr(input int word);
        logic [2:0]  off;
        logic [31:0] w;
        w   = 32'(word);
        off = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
        return {w[12:0], off};
    endfunction

    initial begin
        int t, stale, ren0, wword, rword, op;
        logic [15:0] wa;
        for (int i = 0; i < 8192; i++) begin
            slave_mem[i] = '0;
            ref_mem[i]   = '0;
        end
        for (int i = 0; i < 4; i++) begin
            pend_v[i] = 1'b0;
            pend_d[i] = '0;
        end
        slave_mem[1] = 64'h1234;
        ref_mem[1]   = 64'h1234;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_readies", {61'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 64'd0);
        check("rst_valids", {62'd0, s_axi_bvalid, s_axi_rvalid}, 64'd0);
        check("rst_strobes", {62'd0, o_reg_wen, o_reg_ren}, 64'd0);
        check("rst_addrs", {32'd0, o_reg_waddr, o_reg_raddr}, 64'd0);
        check("rst_wdata", o_reg_wdata, 64'd0);
        check("rst_rdata", s_axi_rdata, 64'd0);
        check("rst_resps", {60'd0, s_axi_bresp, s_axi_rresp}, 64'd0);
        check("rst_errcnt", {48'd0, o_err_cnt}, 64'd0);
        @(negedge clk);
        rst = 0;
        #1;
        check("ready_before_edge", {61'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 64'd0);
        @(posedge clk); #1;
        check("ready_after_edge", {61'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 64'd7);

        // Directed cases.
        axi_write(16'h0010, 64'hDEAD_BEEF_0000_0001, 8'hFF, 0, 0, 0);
        axi_write(16'h0020, 64'h0BAD_F00D_2222_0020, 8'hFF, 3, 0, 1);
        axi_read(16'h0008, 0, 5);
        axi_write(16'h0013, 64'h1111, 8'hFF, 0, 0, 0);
        check("err_cnt_1", {48'd0, o_err_cnt}, 64'd1);
        axi_write(16'h0018, 64'h2222, 8'h0F, 0, 0, 0);
        check("err_cnt_2", {48'd0, o_err_cnt}, 64'd2);
        axi_read(16'h0005, 0, 0);
        check("err_cnt_3", {48'd0, o_err_cnt}, 64'd3);
        fork
            axi_write(16'h0030, 64'hC0FF_EE00_0000_0030, 8'hFF, 0, 0, 0);
            axi_read(16'h0030, 0, 0);
        join
        check("collision_gap", 64'(last_ren_cyc - last_wen_cyc), 64'd1);

        // Randomized traffic: single writes, single reads and overlapping pairs.
        for (int n = 0; n < 60; n++) begin
            op = int'($urandom_range(0, 2));
            wword = int'($urandom_range(0, 31));
            rword = (wword + 1 + int'($urandom_range(0, 30))) % 32;
            wa = rand_addr(wword);
            if (op == 0) begin
                axi_write(wa, {$urandom, $urandom},
                          ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'hFF,
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)));
            end else if (op == 1) begin
                axi_read(rand_addr(rword), 0, int'($urandom_range(0, 3)));
            end else begin
                fork
                    axi_write(wa, {$urandom, $urandom},
                              ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'hFF,
                              int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                              int'($urandom_range(0, 3)));
                    axi_read(rand_addr(rword), int'($urandom_range(0, 3)),
                             int'($urandom_range(0, 3)));
                join
            end
            check("rand_err_cnt", {48'd0, o_err_cnt}, 64'(err_exp));
        end

        // Reset in the middle of a read's wait phase.
        s_axi_arvalid = 1;
        s_axi_araddr  = 16'h0008;
        t = 0;
        while (!s_axi_arready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        check("mid_rst_arready", {63'd0, s_axi_arready}, 64'd1);
        @(posedge clk); #1;
        s_axi_arvalid = 0;
        check("mid_rst_ren", {63'd0, o_reg_ren}, 64'd1);
        @(posedge clk); #2;
        rst = 1;
        #1;
        check("mid_rst_valids", {62'd0, s_axi_rvalid, s_axi_bvalid}, 64'd0);
        check("mid_rst_strobes", {62'd0, o_reg_wen, o_reg_ren}, 64'd0);
        check("mid_rst_readies", {61'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 64'd0);
        check("mid_rst_errcnt", {48'd0, o_err_cnt}, 64'd0);
        err_exp = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        ren0 = ren_count;
        @(posedge clk); #1;
        check("post_rst_readies", {61'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 64'd7);
        stale = 0;
        repeat (8) begin
            if (s_axi_rvalid || s_axi_bvalid) stale++;
            @(posedge clk); #1;
        end
        check("post_rst_no_stale_resp", 64'(stale), 64'd0);
        check("post_rst_no_ren", 64'(ren_count - ren0), 64'd0);
        axi_read(16'h0008, 0, 0);
        check("no_wen_ren_overlap", 64'(both_count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/tlk2711_axil_regif.md
# tlk2711_axil_regif

AXI4-Lite slave bridge that converts PS register accesses, issued over an M_AXI_HPM port, into the TLK2711 subsystem's simple register bus: write strobe, write address, write data, read strobe, read address, read data. It sits directly upstream of the TLK2711 top-level register port and drives its `i_reg_*` inputs. It supports one outstanding write and one outstanding read. The two channels run concurrently, and a same-cycle collision is resolved as write-first.

## Interface
- `AXIL_ADDR_WIDTH`, 16: AXI-Lite address width. Only bits [15:0] are forwarded; higher bits are ignored.
- `DATA_WIDTH`, 64: AXI-Lite and register data width.
- `RD_LATENCY`, 1: cycles from `o_reg_ren` to valid `i_reg_rdata`. Legal range is 1..4.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `s_axi_awvalid`/`s_axi_awready` in/out 1; `s_axi_awaddr` in AXIL_ADDR_WIDTH.
- `s_axi_wvalid`/`s_axi_wready` in/out 1; `s_axi_wdata` in DATA_WIDTH; `s_axi_wstrb` in DATA_WIDTH/8.
- `s_axi_bvalid`/`s_axi_bready` out/in 1; `s_axi_bresp` out 2.
- `s_axi_arvalid`/`s_axi_arready` in/out 1; `s_axi_araddr` in AXIL_ADDR_WIDTH.
- `s_axi_rvalid`/`s_axi_rready` out/in 1; `s_axi_rdata` out DATA_WIDTH; `s_axi_rresp` out 2.
- `o_reg_wen` out 1: single-cycle write strobe.
- `o_reg_waddr` out 16: write byte address.
- `o_reg_wdata` out 64: write data.
- `o_reg_ren` out 1: single-cycle read strobe.
- `o_reg_raddr` out 16: read byte address.
- `i_reg_rdata` in 64: read data, valid RD_LATENCY cycles after `o_reg_ren`.
- `o_err_cnt` out 16: saturating count of SLVERR responses, covering both channels.

## Operation
- **Reset values.** All outputs are 0. This includes every ready, `bvalid`, `rvalid`, `o_reg_wen`, `o_reg_ren`, the address and data outputs, and `o_err_cnt`.
- **Readies.** They are registered and rise on the first clock after `rst` deasserts.
- **Write FSM: W_IDLE → W_ISSUE → W_RESP → W_IDLE.**
  - W_IDLE:
    - `awready` is high until AW has been captured; `wready` is high until W has been captured.
    - AW and W may arrive in either order or in the same cycle.
    - When both are held, go to W_ISSUE.
  - W_ISSUE (one cycle):
    - If `awaddr[2:0]==0` and `wstrb` is all ones: assert `o_reg_wen` with the held address and data. BRESP=OKAY (2'b00).
    - Otherwise: no `wen`, BRESP=SLVERR (2'b10), and `o_err_cnt` increments.
  - W_RESP: `bvalid` is held high until `bready`. Then return to W_IDLE.
- **Read FSM: R_IDLE → R_ISSUE → R_WAIT → R_RESP → R_IDLE.**
  - R_IDLE: `arready` high; capture `araddr`.
  - R_ISSUE:
    - If `araddr[2:0]!=0`: no `ren`. Go directly to R_RESP with `rdata`=0, RRESP=SLVERR, and `o_err_cnt` increments.
    - Else if the write FSM is in W_ISSUE this cycle: stay in R_ISSUE (write-first).
    - Else: assert `o_reg_ren` and go to R_WAIT.
  - R_WAIT: count RD_LATENCY cycles. On the final cycle, register `i_reg_rdata` into `s_axi_rdata`.
  - R_RESP: `rvalid` is held high until `rready`. RRESP=OKAY.
- **Stability.** `s_axi_rdata`, `rresp` and `bresp` are stable while the corresponding valid is high.
- **Error counter.** `o_err_cnt` saturates at 16'hFFFF. If both channels raise an error in the same cycle, it increments by 2 (saturating).
- **Reset mid-transaction.** The transaction is dropped. Valids and strobes fall asynchronously, and no response is produced after reset.

## Timing
- **Write, AW and W accepted together in cycle 0:**
  - `o_reg_wen` in cycle 1.
  - `bvalid` in cycle 2.
  - Earliest next AW/W acceptance is the cycle after the B handshake.
- **Write, W accepted k cycles after AW:** `wen` occurs in cycle k+1.
- **Read, AR accepted in cycle 0:**
  - `o_reg_ren` in cycle 1.
  - `i_reg_rdata` is sampled at the end of cycle 1+RD_LATENCY.
  - `rvalid` in cycle 2+RD_LATENCY. With the default RD_LATENCY this is cycle 3.
- **Collision.** Each write-first collision adds exactly 1 cycle of read latency.
- **Back-pressure.** `bready` or `rready` held low stalls only its own channel. The other channel continues.

## Structure
- Shared package `tlk2711_regif_pkg` holds:
  - the AXI response constants RESP_OKAY and RESP_SLVERR;
  - the write and read state enums;
  - REG_ADDR_W=16 and REG_DATA_W=64.
- There is no sub-module. Both FSMs, the latency counter and the error counter live in one file, in the 150–250 line range.

## Test plan
- **Aligned write.** AW(0x0010) and W(0xDEAD_BEEF_0000_0001, strb 0xFF) in the same cycle → `wen` in cycle 1 with `waddr`=0x0010 and matching data; `bvalid` in cycle 2 with BRESP=00.
- **W before AW.** W first, AW 3 cycles later (0x0020) → exactly one `wen` pulse, occurring the cycle after AW acceptance; BRESP=00.
- **Read.** AR(0x0008) with `i_reg_rdata`=0x1234 presented at ren+1 (RD_LATENCY=1) → `rvalid` at cycle 3 with `rdata`=0x1234 and RRESP=00. Hold `rready` low 5 cycles → `rdata` stays stable.
- **Errors.** AW 0x0013 → no `wen`, BRESP=10, `o_err_cnt`=1. Then wstrb 0x0F → BRESP=10, `o_err_cnt`=2. Then AR 0x0005 → RRESP=10, `rdata`=0, `o_err_cnt`=3.
- **Write/read collision.** Time AR so that R_ISSUE coincides with W_ISSUE (both at 0x0030) → `ren` occurs one cycle after `wen`, never in the same cycle.
- **Reset mid-read.** Assert `rst` during R_WAIT → `rvalid`, `ren` and all readies are 0 immediately; after release the readies return to 1 and no stale `rvalid` appears.
